// File: rtl/router_pkg.sv
// Shared constants and types for the router output FIFOs.
// Holds the FIFO geometry and packet header field positions
// (length in [7:2], destination address in [1:0]).
package router_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = 5;   // 4 index bits + 1 wrap bit
  localparam int IDX_W      = PTR_W - 1;
  localparam int CNT_W      = 6;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  // Bytes still to be read after the header: payload length plus parity.
  function automatic logic [CNT_W-1:0] hdr_count(input logic [CNT_W-1:0] len);
    return len + CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: 16 x 9 output FIFO for one router destination port.
// Each entry stores {hdr, byte}; hdr marks a packet header byte. A packet
// counter tracks the bytes left in the packet being read so that data_out
// returns to 8'h00 once a packet has fully drained.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   soft_reset  synchronous active-high flush (read timeout)
//   write_enb   write strobe
//   read_enb    read strobe
//   lfd_state   data_in is a header byte
//   data_in     byte to store
//   data_out    registered read data
//   full/empty  occupancy flags from registered pointers
module router_fifo
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  fifo_entry_t       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data_out;

  logic        w_empty;
  logic        w_full;
  logic        w_flush;
  logic        w_wr;
  logic        w_rd;
  fifo_entry_t w_rd_entry;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Same index, opposite lap: writer is exactly one lap ahead.
  assign w_full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                   (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
  assign w_flush = reset | soft_reset;
  // Gated by this cycle's flags, so a read/write pair at full only reads
  // and at empty only writes.
  assign w_wr    = write_enb & ~w_full;
  assign w_rd    = read_enb & ~w_empty;

  assign w_rd_entry = r_mem[r_rd_ptr[IDX_W-1:0]];

  // Storage has no reset; a write coincident with a flush is dropped so the
  // array never changes while the pointers are being cleared.
  always_ff @(posedge clock) begin
    if (w_wr && !w_flush)
      r_mem[r_wr_ptr[IDX_W-1:0]] <= '{hdr: lfd_state, data: data_in};
  end

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);

      if (w_rd) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_data_out <= w_rd_entry.data;
        if (w_rd_entry.hdr)
          r_cnt <= hdr_count(w_rd_entry.data[HDR_LEN_MSB:HDR_LEN_LSB]);
        else if (r_cnt != '0)
          r_cnt <= r_cnt - CNT_W'(1);
      end else if (r_cnt == '0) begin
        // Packet fully drained: idle the output bus.
        r_data_out <= '0;
      end
    end
  end

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule
